adc_ramp_checker: RTL and testbench
===================================

ADC_RAMP_CHECKER -- requirements
Module: adc_ramp_checker

Interface
REQ-001 Parameter DATA_W, default 14: ADC sample width.
REQ-002 Parameter LOCK_N, default 16: consecutive correct increments needed to declare lock.
REQ-003 Parameter MISS_N, default 4: consecutive mismatches in LOCKED that drop lock.
REQ-004 Parameter ERR_W, default 16: error counter width.
REQ-005 clk_i  input  1  sample clock (200 MHz); the only clock.
REQ-006 reset_i  input  1  reset, asynchronous, active-low.
REQ-007 data_i  input  DATA_W  ADC sample carrying the free-running ramp pattern.
REQ-008 valid_i  input  1  data_i is valid this cycle; samples with valid_i=0 are ignored.
REQ-009 clear_i  input  1  synchronous clear of the statistics counters.
REQ-010 locked_o  output  1  checker is locked to the ramp.
REQ-011 error_o  output  1  one-cycle pulse per mismatching sample while LOCKED.
REQ-012 err_cnt_o  output  ERR_W  saturating count of LOCKED-state mismatches.
REQ-013 sample_cnt_o  output  32  count of valid samples, wrapping.
REQ-014 state_o  output  2  FSM state: 0 UNLOCKED, 1 ACQUIRE, 2 LOCKED.

Function
REQ-015 Expected next value is the previous accepted sample + 1 modulo 2^DATA_W; 2^DATA_W-1 followed by 0 is a match.
REQ-016 UNLOCKED: the first valid sample loads expected=data_i+1 and run=0; next state is ACQUIRE.
REQ-017 ACQUIRE, valid match: run increments; when run reaches LOCK_N, next state is LOCKED and run clears.
REQ-018 ACQUIRE, valid mismatch: expected=data_i+1, run=0; state stays ACQUIRE; error_o is not asserted and err_cnt_o is not incremented.
REQ-019 LOCKED, valid match: expected increments and the miss counter clears.
REQ-020 LOCKED, valid mismatch: error_o=1 on the next cycle; err_cnt_o increments, saturating at all-ones; expected=data_i+1 (resync); the miss counter increments.
REQ-021 LOCKED: when the miss counter reaches MISS_N, next state is UNLOCKED with locked_o=0; the error from that sample is still pulsed and counted.
REQ-022 Cycles with valid_i=0 change no state, expected value, run, or miss counter, and error_o=0.
REQ-023 All outputs are registered. locked_o, state_o, error_o, and the counters reflect a sample exactly one clk_i cycle after it is presented.
REQ-024 sample_cnt_o increments on every valid sample in any state, wrapping from 2^32-1 to 0.
REQ-025 clear_i=1: err_cnt_o=0 and sample_cnt_o=0 next cycle; clear_i has priority over a simultaneous increment.
REQ-026 clear_i has no effect on the FSM, expected value, locked_o, or the error_o pulse.

Reset
REQ-027 reset_i=0 asynchronously forces state UNLOCKED, locked_o=0, error_o=0, err_cnt_o=0, sample_cnt_o=0, state_o=0, and expected, run, and miss counters to 0.
REQ-028 Deassertion of reset_i is synchronized to clk_i. The first valid sample accepted after deassertion is handled as in UNLOCKED.
REQ-029 Reset asserted while LOCKED drops locked_o immediately, without waiting for a clock edge.

Verification
REQ-030 Continuous ramp from 0, valid_i=1 -> state_o: 0 -> 1 after 1 sample; locked_o=1 one cycle after the 17th sample; err_cnt_o=0.
REQ-031 Locked ramp through 16382, 16383, 0, 1 -> no error_o; locked_o stays 1.
REQ-032 Locked, inject a single value 500 in place of 100, then resume at 101 -> error_o pulses twice (for 500 and 101), err_cnt_o=2, locked_o stays 1.
REQ-033 Locked, 4 consecutive random mismatches -> err_cnt_o=4; locked_o=0 and state_o=0 one cycle after the 4th.
REQ-034 err_cnt_o at 0xFFFF plus a further mismatch -> stays 0xFFFF; clear_i asserted together with a mismatch -> err_cnt_o=0, error_o=1.
REQ-035 valid_i toggling 1/0 on a ramp -> identical lock timing, counted in valid samples; reset_i pulsed low mid-LOCKED -> all outputs 0 asynchronously, then reacquire takes 17 valid samples.

Source files
------------

// File: rtl/adc_ramp_checker.sv
// adc_ramp_checker: locks onto a free-running ADC ramp test pattern, flags
// samples that break the +1 sequence while locked, and keeps statistics.
//
// Input qualifier: data_i is consumed only on cycles where valid_i=1. There
// is no ready/backpressure; every valid sample is accepted on the rising
// clk_i edge, and all outputs reflect it one cycle later.
module adc_ramp_checker #(
    parameter int DATA_W = 14,
    parameter int LOCK_N = 16,
    parameter int MISS_N = 4,
    parameter int ERR_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic              locked_o,
    output logic              error_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [31:0]       sample_cnt_o,
    output logic [1:0]        state_o
);

    localparam int RUN_W  = (LOCK_N > 1) ? $clog2(LOCK_N + 1) : 1;
    localparam int MISS_W = (MISS_N > 1) ? $clog2(MISS_N + 1) : 1;

    // Values of run/miss on the sample that completes lock or drops it.
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_N - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_N - 1);
    localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] expected;
    logic [RUN_W-1:0]  run;
    logic [MISS_W-1:0] miss;
    logic [1:0]        rst_sync;
    logic              rst_n;
    logic              match;
    logic              locked_miss;

    // Reset asserts immediately, releases two clk_i edges after reset_i rises.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n       = rst_sync[1];
    assign match       = (data_i == expected);
    assign locked_miss = valid_i && (state == ST_LOCKED) && !match;
    assign state_o     = state;

    // Lock FSM: tracks the expected next ramp value and the run/miss streaks.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_UNLOCKED;
            locked_o <= 1'b0;
            error_o  <= 1'b0;
            expected <= '0;
            run      <= '0;
            miss     <= '0;
        end else begin
            error_o <= 1'b0;
            if (valid_i) begin
                case (state)
                    ST_UNLOCKED: begin
                        expected <= data_i + DATA_ONE;
                        run      <= '0;
                        miss     <= '0;
                        state    <= ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        // On a mismatch restart the streak from this sample.
                        expected <= data_i + DATA_ONE;
                        if (match) begin
                            if (run == RUN_LAST) begin
                                run      <= '0;
                                miss     <= '0;
                                state    <= ST_LOCKED;
                                locked_o <= 1'b1;
                            end else begin
                                run <= run + 1'b1;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        // data_i+1 equals expected+1 on a match, and resyncs on a miss.
                        expected <= data_i + DATA_ONE;
                        if (match) begin
                            miss <= '0;
                        end else begin
                            error_o <= 1'b1;
                            if (miss == MISS_LAST) begin
                                miss     <= '0;
                                state    <= ST_UNLOCKED;
                                locked_o <= 1'b0;
                            end else begin
                                miss <= miss + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_UNLOCKED;
                        locked_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Statistics: clear wins over any increment in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_o    <= '0;
            sample_cnt_o <= '0;
        end else if (clear_i) begin
            err_cnt_o    <= '0;
            sample_cnt_o <= '0;
        end else begin
            if (valid_i) begin
                sample_cnt_o <= sample_cnt_o + 32'd1;
            end
            if (locked_miss && (err_cnt_o != {ERR_W{1'b1}})) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_ramp_checker.sv
// Bench for adc_ramp_checker: table of acquisition vectors, hand-written
// corner sequences and random traffic against a sample-level reference model.
module tb_adc_ramp_checker;

    localparam int DW     = 14;
    localparam int MOD    = 1 << DW;
    localparam int LOCK_N = 16;
    localparam int MISS_N = 4;
    localparam int EW     = 10;
    localparam int EMAX   = (1 << EW) - 1;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          locked_o;
    logic          error_o;
    logic [EW-1:0] err_cnt_o;
    logic [31:0]   sample_cnt_o;
    logic [1:0]    state_o;

    int n_checks = 0;
    int n_fail   = 0;

    adc_ramp_checker #(
        .DATA_W(DW),
        .LOCK_N(LOCK_N),
        .MISS_N(MISS_N),
        .ERR_W (EW)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .clear_i     (clear_i),
        .locked_o    (locked_o),
        .error_o     (error_o),
        .err_cnt_o   (err_cnt_o),
        .sample_cnt_o(sample_cnt_o),
        .state_o     (state_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Sample-level view: the last accepted sample, the length of the current
    // correct-increment streak and the current streak of locked mismatches.
    bit          m_have;
    int          m_prev;
    int          m_run;
    int          m_miss;
    bit          m_locked;
    bit          m_err;
    int          m_ec;
    logic [31:0] m_sc;

    function automatic void model_reset();
        m_have = 0; m_prev = 0; m_run = 0; m_miss = 0;
        m_locked = 0; m_err = 0; m_ec = 0; m_sc = 0;
    endfunction

    function automatic int model_state();
        return m_locked ? 2 : (m_have ? 1 : 0);
    endfunction

    function automatic int model_next();
        return (m_prev + 1) % MOD;
    endfunction

    function automatic void model_step(bit v, bit c, int d);
        m_err = 0;
        if (v) begin
            m_sc = m_sc + 32'd1;
            if (!m_have) begin
                m_have = 1;
                m_run  = 0;
            end else if (!m_locked) begin
                if (d == model_next()) begin
                    m_run++;
                    if (m_run == LOCK_N) begin
                        m_locked = 1;
                        m_run    = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                if (d == model_next()) begin
                    m_miss = 0;
                end else begin
                    m_err = 1;
                    if (m_ec < EMAX) m_ec++;
                    m_miss++;
                    if (m_miss == MISS_N) begin
                        m_locked = 0;
                        m_have   = 0;
                        m_miss   = 0;
                    end
                end
            end
            m_prev = d;
        end
        if (c) begin
            m_ec = 0;
            m_sc = 0;
        end
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".state"},  32'(state_o),   32'(model_state()));
        check({tag, ".locked"}, 32'(locked_o),  32'(m_locked));
        check({tag, ".error"},  32'(error_o),   32'(m_err));
        check({tag, ".errcnt"}, 32'(err_cnt_o), 32'(m_ec));
        check({tag, ".smpcnt"}, sample_cnt_o,   m_sc);
    endtask

    // ---------------- driver ----------------
    // Present one cycle of inputs at the falling edge, then check #1 after
    // the rising edge that consumes them.
    task automatic step(input string tag, input bit v, input bit c, input int d);
        @(negedge clk_i);
        valid_i = v;
        clear_i = c;
        data_i  = DW'(d);
        model_step(v, c, d);
        @(posedge clk_i);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        valid_i = 1'b0;
        clear_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        // Synchronizer release: samples are ignored until it completes.
        repeat (3) step("rst_idle", 0, 0, 0);
    endtask

    function automatic int bad_value();
        // Any value other than the one the ramp expects next.
        return (model_next() + 2 + int'($urandom_range(0, 1000))) % MOD;
    endfunction

    // ---------------- table vectors ----------------
    typedef struct {
        bit v;
        bit c;
        int d;
        int e_state;
        bit e_locked;
        bit e_err;
        int e_scnt;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int d;
        int ec_before;

        // Continuous ramp from 0: ACQUIRE after sample 1, LOCKED after 17.
        for (int i = 0; i < 20; i++) begin
            tbl[i] = '{v: 1'b1, c: 1'b0, d: i, e_state: (i >= 16) ? 2 : 1,
                       e_locked: (i >= 16), e_err: 1'b0, e_scnt: i + 1};
        end
        tbl[19].c      = 1'b1;
        tbl[19].e_scnt = 0;

        // Reset state before any clock releases the reset.
        #2;
        check("reset.state",  32'(state_o),   32'd0);
        check("reset.locked", 32'(locked_o),  32'd0);
        check("reset.errcnt", 32'(err_cnt_o), 32'd0);
        check("reset.smpcnt", sample_cnt_o,   32'd0);
        do_reset();

        foreach (tbl[i]) begin
            step("tbl", tbl[i].v, tbl[i].c, tbl[i].d);
            check("tbl.state",  32'(state_o),   32'(tbl[i].e_state));
            check("tbl.locked", 32'(locked_o),  32'(tbl[i].e_locked));
            check("tbl.error",  32'(error_o),   32'(tbl[i].e_err));
            check("tbl.errcnt", 32'(err_cnt_o), 32'd0);
            check("tbl.smpcnt", sample_cnt_o,   32'(tbl[i].e_scnt));
        end

        // Ramp wrap while locked: acquire from 16360, run through 16383 -> 0.
        do_reset();
        d = 16360;
        for (int i = 0; i < 30; i++) begin
            step("wrap", 1, 0, d);
            if (i >= 16) begin
                check("wrap.locked", 32'(locked_o), 32'd1);
                check("wrap.error",  32'(error_o),  32'd0);
            end
            d = (d + 1) % MOD;
        end

        // Single injected value: 500 replaces 100, then 101 resumes.
        while (d != 100) begin
            step("ramp", 1, 0, d);
            d++;
        end
        ec_before = m_ec;
        step("inj500", 1, 0, 500);
        check("inj500.error", 32'(error_o), 32'd1);
        step("inj101", 1, 0, 101);
        check("inj101.error", 32'(error_o), 32'd1);
        step("inj102", 1, 0, 102);
        check("inj102.error",  32'(error_o),   32'd0);
        check("inj.errcnt",    32'(err_cnt_o), 32'(ec_before + 2));
        check("inj.locked",    32'(locked_o),  32'd1);

        // Four consecutive mismatches drop lock.
        step("clr", 0, 1, 0);
        check("clr.errcnt", 32'(err_cnt_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step("miss", 1, 0, bad_value());
            check("miss.error", 32'(error_o), 32'd1);
            if (i < 3) check("miss.locked", 32'(locked_o), 32'd1);
        end
        check("miss4.errcnt", 32'(err_cnt_o), 32'd4);
        check("miss4.locked", 32'(locked_o),  32'd0);
        check("miss4.state",  32'(state_o),   32'd0);

        // Relock, then reset asynchronously mid-LOCKED.
        d = 7;
        for (int i = 0; i < 20; i++) begin
            step("relock", 1, 0, d);
            d++;
        end
        check("relock.locked", 32'(locked_o), 32'd1);
        #2;
        reset_i = 1'b0;
        #1;
        check("async.locked", 32'(locked_o),  32'd0);
        check("async.state",  32'(state_o),   32'd0);
        check("async.error",  32'(error_o),   32'd0);
        check("async.errcnt", 32'(err_cnt_o), 32'd0);
        check("async.smpcnt", sample_cnt_o,   32'd0);
        do_reset();

        // Reacquire with valid_i toggling: lock counted in valid samples.
        d = 1234;
        for (int i = 1; i <= 17; i++) begin
            step("tog", 1, 0, d);
            d++;
            check("tog.state", 32'(state_o), (i == 17) ? 32'd2 : 32'd1);
            check("tog.locked", 32'(locked_o), (i == 17) ? 32'd1 : 32'd0);
            step("tog_idle", 0, 0, 3);
        end

        // Saturation: groups of 3 mismatches + 1 match keep lock.
        while (m_ec < EMAX) begin
            for (int k = 0; k < 3; k++) step("sat_mm", 1, 0, bad_value());
            step("sat_ok", 1, 0, model_next());
        end
        check("sat.errcnt", 32'(err_cnt_o), 32'(EMAX));
        step("sat_more", 1, 0, bad_value());
        check("sat_more.errcnt", 32'(err_cnt_o), 32'(EMAX));
        check("sat_more.error",  32'(error_o),   32'd1);
        step("sat_ok2", 1, 0, model_next());
        step("clr_mm", 1, 1, bad_value());
        check("clr_mm.errcnt", 32'(err_cnt_o), 32'd0);
        check("clr_mm.error",  32'(error_o),   32'd1);
        check("clr_mm.locked", 32'(locked_o),  32'd1);

        // Random traffic: mostly ramp, sprinkled mismatches, idles and clears.
        for (int i = 0; i < 3000; i++) begin
            int  r;
            bit  v;
            bit  c;
            r = int'($urandom_range(0, 99));
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 59) == 0);
            d = (r < 90) ? model_next() : int'($urandom_range(0, MOD - 1));
            step("rand", v, c, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
